tamagotchi_btn_cond: RTL and testbench

//   Input-side producer for the pet FSM: conditions raw board push-buttons into the

---
 rtl/tamagotchi_btn_cond.sv | 186 ++++++++++++++++++
 tb/tb_tamagotchi_btn_cond.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_btn_cond.sv
// Button conditioner for the pet FSM.
// Four channels (health, food, reset, test). Each one runs 2-FF sync -> debounce FSM.
// The reset and test channels also detect a long hold and emit a one-cycle strobe.
// Channel index map: 0 = salud, 1 = ali, 2 = rst, 3 = test.
module tamagotchi_btn_cond #(
  parameter bit          ACT_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned HOLD_CYC     = 250_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic salud_raw,
  input  logic ali_raw,
  input  logic rst_raw,
  input  logic test_raw,
  output logic btn_salud,
  output logic btn_ali,
  output logic salud_pulse,
  output logic ali_pulse,
  output logic btn_reset,
  output logic btn_test,
  output logic hold_active
);

  localparam int unsigned NumCh = 4;
  localparam int unsigned CW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HW    = $clog2(HOLD_CYC + 1);

  localparam logic [CW-1:0] DbMax    = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] DbOne    = CW'(1);
  localparam logic [HW-1:0] HoldMax  = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD_CYC - 1);

  // Only the reset and test channels do long-hold detection.
  localparam logic [NumCh-1:0] IsLong = 4'b1100;

  typedef enum logic [2:0] {
    StIdle,
    StDbPress,
    StPressed,
    StFired,
    StDbRel
  } state_e;

  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] sync1_q;
  logic [NumCh-1:0] sync2_q;
  logic [NumCh-1:0] pressed;

  state_e           state_q      [NumCh];
  logic [CW-1:0]    cnt_q        [NumCh];
  logic [HW-1:0]    hcnt_q       [NumCh];
  logic             from_fired_q [NumCh];

  logic [NumCh-1:0] accept;
  logic [NumCh-1:0] fire_req;
  logic             rst_fire;
  logic             test_fire;

  logic [1:0]       pulse_q;
  logic             btn_reset_q;
  logic             btn_test_q;

  assign raw = {test_raw, rst_raw, ali_raw, salud_raw};

  // Two-stage synchronizer; reset loads the released (not-pressed) pin level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= {NumCh{ACT_LOW}};
      sync2_q <= {NumCh{ACT_LOW}};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ {NumCh{ACT_LOW}};

  // Press acceptance and long-hold fire requests, decoded from current state.
  always_comb begin
    accept   = '0;
    fire_req = '0;
    for (int c = 0; c < NumCh; c++) begin
      accept[c]   = (state_q[c] == StDbPress) && pressed[c] && (cnt_q[c] == DbMax);
      fire_req[c] = IsLong[c] && (state_q[c] == StPressed) && pressed[c] &&
                    (hcnt_q[c] == HoldLast);
    end
  end

  // Reset wins a same-cycle tie; the test channel still moves to FIRED silently.
  assign rst_fire  = fire_req[2];
  assign test_fire = fire_req[3] & ~fire_req[2];

  // Per-channel debounce / long-hold FSM plus registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NumCh; c++) begin
        state_q[c]      <= StIdle;
        cnt_q[c]        <= '0;
        hcnt_q[c]       <= '0;
        from_fired_q[c] <= 1'b0;
      end
      pulse_q     <= '0;
      btn_reset_q <= 1'b0;
      btn_test_q  <= 1'b0;
    end else begin
      pulse_q     <= accept[1:0];
      btn_reset_q <= rst_fire;
      btn_test_q  <= test_fire;
      for (int c = 0; c < NumCh; c++) begin
        unique case (state_q[c])
          StIdle: begin
            if (pressed[c]) begin
              state_q[c] <= StDbPress;
              cnt_q[c]   <= DbOne;
            end
          end
          StDbPress: begin
            if (!pressed[c]) begin
              state_q[c] <= StIdle;
              cnt_q[c]   <= '0;
            end else if (accept[c]) begin
              state_q[c]      <= StPressed;
              cnt_q[c]        <= '0;
              hcnt_q[c]       <= '0;
              from_fired_q[c] <= 1'b0;
            end else if (cnt_q[c] != DbMax) begin
              cnt_q[c] <= cnt_q[c] + DbOne;
            end
          end
          StPressed: begin
            if (!pressed[c]) begin
              state_q[c]      <= StDbRel;
              cnt_q[c]        <= DbOne;
              from_fired_q[c] <= 1'b0;
            end else if (fire_req[c]) begin
              state_q[c] <= StFired;
            end else if (IsLong[c] && (hcnt_q[c] != HoldMax)) begin
              hcnt_q[c] <= hcnt_q[c] + HW'(1);
            end
          end
          StFired: begin
            if (!pressed[c]) begin
              state_q[c]      <= StDbRel;
              cnt_q[c]        <= DbOne;
              from_fired_q[c] <= 1'b1;
            end
          end
          StDbRel: begin
            // A bounce back to pressed resumes where we were; hold progress is kept.
            if (pressed[c]) begin
              state_q[c] <= from_fired_q[c] ? StFired : StPressed;
              cnt_q[c]   <= '0;
            end else if (cnt_q[c] == DbMax) begin
              state_q[c]      <= StIdle;
              cnt_q[c]        <= '0;
              hcnt_q[c]       <= '0;
              from_fired_q[c] <= 1'b0;
            end else begin
              cnt_q[c] <= cnt_q[c] + DbOne;
            end
          end
          default: begin
            state_q[c] <= StIdle;
            cnt_q[c]   <= '0;
            hcnt_q[c]  <= '0;
          end
        endcase
      end
    end
  end

  assign btn_salud   = (state_q[0] == StPressed) || (state_q[0] == StDbRel);
  assign btn_ali     = (state_q[1] == StPressed) || (state_q[1] == StDbRel);
  assign salud_pulse = pulse_q[0];
  assign ali_pulse   = pulse_q[1];
  assign btn_reset   = btn_reset_q;
  assign btn_test    = btn_test_q;

  // Armed-but-not-fired indication for the two long-hold channels.
  assign hold_active = (state_q[2] == StPressed) ||
                       ((state_q[2] == StDbRel) && !from_fired_q[2]) ||
                       (state_q[3] == StPressed) ||
                       ((state_q[3] == StDbRel) && !from_fired_q[3]);

endmodule

// File: tb/tb_tamagotchi_btn_cond.sv
// Directed bench for tamagotchi_btn_cond with ACT_LOW=1, DEBOUNCE_CYC=4, HOLD_CYC=20.
module tb_tamagotchi_btn_cond;

  logic clk = 1'b0;
  logic rst_n;
  logic salud_raw, ali_raw, rst_raw, test_raw;
  logic btn_salud, btn_ali, salud_pulse, ali_pulse, btn_reset, btn_test, hold_active;

  tamagotchi_btn_cond #(
    .ACT_LOW      (1'b1),
    .DEBOUNCE_CYC (4),
    .HOLD_CYC     (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .salud_raw   (salud_raw),
    .ali_raw     (ali_raw),
    .rst_raw     (rst_raw),
    .test_raw    (test_raw),
    .btn_salud   (btn_salud),
    .btn_ali     (btn_ali),
    .salud_pulse (salud_pulse),
    .ali_pulse   (ali_pulse),
    .btn_reset   (btn_reset),
    .btn_test    (btn_test),
    .hold_active (hold_active)
  );

  always #5 clk = ~clk;

  // Output bits: {hold_active, btn_test, btn_reset, ali_pulse, salud_pulse, btn_ali, btn_salud}
  typedef struct {
    int         scen;
    int         lo;
    int         hi;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  function automatic logic [6:0] outs();
    return {hold_active, btn_test, btn_reset, ali_pulse, salud_pulse, btn_ali, btn_salud};
  endfunction

  // Raw pin levels per scenario and edge: {rst_n, test, rst, ali, salud}; pins low = pressed.
  function automatic logic [4:0] stim(input int scen, input int e);
    logic rn, t, r, a, s;
    rn = 1'b1; t = 1'b1; r = 1'b1; a = 1'b1; s = 1'b1;
    case (scen)
      1: s = !(e >= 10 && e < 40);
      2: begin
        if (e >= 10 && e < 40) a = (((e - 10) / 2) % 2) != 0;
        else if (e >= 60)      a = 1'b0;
      end
      3: r = !(e >= 10 && e < 50);
      4: begin
        r = !(e >= 10 && e < 50);
        t = !(e >= 10 && e < 50);
      end
      5: begin
        t  = !(e >= 10);
        rn = (e != 25);
      end
      6: s = !(e >= 10 && !(e == 30 || e == 31));
      7: r = !(((e >= 5) && (e < 50) && !(e == 40 || e == 41)) || (e >= 60));
      default: ;
    endcase
    return {rn, t, r, a, s};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {test_raw, rst_raw, ali_raw, salud_raw} = 4'b1111;
    repeat (2) @(posedge clk);
  endtask

  task automatic step(input int scen, input int e);
    @(negedge clk);
    {rst_n, test_raw, rst_raw, ali_raw, salud_raw} = stim(scen, e);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int want);
    vec_cnt++;
    if (got != want) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int n_rst, first_rst, second_rst, n_test, ha_bad, ha_late;

    rst_n = 1'b0;
    {test_raw, rst_raw, ali_raw, salud_raw} = 4'b1111;

    // Salud press, held, then released at 40.
    tbl.push_back('{1, 0, 15, 7'b0000000});
    tbl.push_back('{1, 16, 16, 7'b0000101});
    tbl.push_back('{1, 17, 45, 7'b0000001});
    tbl.push_back('{1, 46, 79, 7'b0000000});
    // Ali bouncing 2-cycle toggles: nothing; clean press at 60 accepted at 66.
    tbl.push_back('{2, 0, 65, 7'b0000000});
    tbl.push_back('{2, 66, 66, 7'b0001010});
    tbl.push_back('{2, 67, 79, 7'b0000010});
    // Reset long hold.
    tbl.push_back('{3, 0, 15, 7'b0000000});
    tbl.push_back('{3, 16, 35, 7'b1000000});
    tbl.push_back('{3, 36, 36, 7'b0010000});
    tbl.push_back('{3, 37, 79, 7'b0000000});
    // Both long channels together: reset wins.
    tbl.push_back('{4, 0, 15, 7'b0000000});
    tbl.push_back('{4, 16, 35, 7'b1000000});
    tbl.push_back('{4, 36, 36, 7'b0010000});
    tbl.push_back('{4, 37, 79, 7'b0000000});
    // Test hold interrupted by reset at 25; re-accepted at 32, fires at 52.
    tbl.push_back('{5, 0, 15, 7'b0000000});
    tbl.push_back('{5, 16, 24, 7'b1000000});
    tbl.push_back('{5, 25, 31, 7'b0000000});
    tbl.push_back('{5, 32, 51, 7'b1000000});
    tbl.push_back('{5, 52, 52, 7'b0100000});
    tbl.push_back('{5, 53, 79, 7'b0000000});
    // Salud held with a 2-cycle glitch at 30: level stays, no pulse.
    tbl.push_back('{6, 0, 15, 7'b0000000});
    tbl.push_back('{6, 16, 16, 7'b0000101});
    tbl.push_back('{6, 17, 79, 7'b0000001});

    for (int s = 1; s <= 6; s++) begin
      do_reset();
      for (int e = 0; e < 80; e++) begin
        step(s, e);
        foreach (tbl[i]) begin
          if (tbl[i].scen == s && e >= tbl[i].lo && e <= tbl[i].hi) begin
            vec_cnt++;
            if (outs() !== tbl[i].exp) begin
              err_cnt++;
              $display("FAIL scen%0d edge%0d: got %b expected %b", s, e, outs(), tbl[i].exp);
            end
          end
        end
      end
    end

    // Re-press bounce after firing must not re-strobe; full release re-arms.
    do_reset();
    n_rst = 0; first_rst = -1; second_rst = -1; n_test = 0; ha_bad = 0; ha_late = 0;
    for (int e = 0; e < 100; e++) begin
      step(7, e);
      if (btn_reset === 1'b1) begin
        n_rst++;
        if (first_rst < 0) first_rst = e;
        else if (second_rst < 0) second_rst = e;
      end
      if (btn_test === 1'b1) n_test++;
      if (e >= 31 && e <= 59 && hold_active !== 1'b0) ha_bad++;
      if (e == 70) ha_late = (hold_active === 1'b1) ? 1 : 0;
    end
    check("rehold_strobe_count", n_rst, 2);
    check("rehold_first_edge", first_rst, 31);
    check("rehold_second_edge", second_rst, 86);
    check("rehold_test_quiet", n_test, 0);
    check("rehold_ha_after_fire", ha_bad, 0);
    check("rehold_ha_rearmed", ha_late, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
